// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: the default word width, the skid-buffer
// state names and a select range check used by the operand selectors.
package mips_pkg;

  localparam int WORD_W = 32;

  // Buffer occupancy, derived from the valid bits and kept for debug visibility
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_t;

  // True when a select value addresses one of the n existing sources
  function automatic logic sel_in_range(input int unsigned sel, input int unsigned n);
    return sel < n;
  endfunction

endpackage

// File: rtl/mux_n.sv
// Combinational N-way selector. Out-of-range selects produce zero and raise
// oor so the caller can flag the bad beat.
module mux_n
  import mips_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int N     = 4,
  parameter int SELW  = $clog2(N)
) (
  input  logic [N*WIDTH-1:0] data_in,
  input  logic [SELW-1:0]    sel,
  output logic [WIDTH-1:0]   data_out,
  output logic               oor
);

  // Scan the sources for the matching index; nothing matches when out of range
  always_comb begin
    data_out = '0;
    oor      = !sel_in_range(32'(sel), N);
    for (int k = 0; k < N; k++) begin
      if (sel == SELW'(k)) begin
        data_out = data_in[k*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/mux_pipe.sv
// Pipelined N-way operand selector with a valid/ready handshake. A main
// output register plus one skid register keep full throughput while
// in_ready depends only on registered state. Accepted beats are counted
// and any out-of-range select is remembered until reset.
module mux_pipe
  import mips_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int N     = 4,
  parameter int SELW  = $clog2(N),
  parameter int CNTW  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N*WIDTH-1:0]  data_in,
  input  logic [SELW-1:0]     sel,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [WIDTH-1:0]    out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                sel_err,
  output logic [CNTW-1:0]     beat_cnt
);

  logic [WIDTH-1:0] cap_data;
  logic             cap_oor;
  logic [WIDTH-1:0] main_data;
  logic             main_valid;
  logic [WIDTH-1:0] skid_data;
  logic             skid_valid;
  logic             accept;
  logic             drain;
  buf_state_t       state;

  mux_n #(
    .WIDTH (WIDTH),
    .N     (N),
    .SELW  (SELW)
  ) u_mux (
    .data_in  (data_in),
    .sel      (sel),
    .data_out (cap_data),
    .oor      (cap_oor)
  );

  // Occupancy state and handshake qualifiers; in_ready never looks at out_ready
  always_comb begin
    state = EMPTY;
    if (skid_valid) begin
      state = FULL;
    end else if (main_valid) begin
      state = ONE;
    end
    in_ready = (state != FULL) && !rst;
    accept   = in_valid && in_ready;
    drain    = main_valid && out_ready;
  end

  // Two-entry buffer: new beats go to main when it is free or being drained,
  // otherwise into skid; a drain from FULL promotes skid into main
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_data  <= '0;
      main_valid <= 1'b0;
      skid_data  <= '0;
      skid_valid <= 1'b0;
    end else begin
      if (accept && (!main_valid || drain)) begin
        main_data  <= cap_data;
        main_valid <= 1'b1;
      end else if (accept) begin
        skid_data  <= cap_data;
        skid_valid <= 1'b1;
      end else if (drain) begin
        if (skid_valid) begin
          main_data  <= skid_data;
          skid_valid <= 1'b0;
        end else begin
          main_valid <= 1'b0;
        end
      end
    end
  end

  // Beat counter wraps naturally; the error flag is sticky until reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt <= '0;
      sel_err  <= 1'b0;
    end else if (accept) begin
      beat_cnt <= beat_cnt + 1'b1;
      if (cap_oor) begin
        sel_err <= 1'b1;
      end
    end
  end

  assign out_data  = main_data;
  assign out_valid = main_valid;

endmodule

// File: tb/tb_mux_pipe.sv
// Directed bench for mux_pipe: a 4-source instance with a 4-bit counter for
// streaming, back-pressure, wrap and reset, and a 3-source instance for
// out-of-range selects.
module tb_mux_pipe;

  logic        clk;
  logic        rst;

  logic [31:0] a_data_in;
  logic [1:0]  a_sel;
  logic        a_in_valid;
  logic        a_in_ready;
  logic [7:0]  a_out_data;
  logic        a_out_valid;
  logic        a_out_ready;
  logic        a_sel_err;
  logic [3:0]  a_beat_cnt;

  logic [23:0] b_data_in;
  logic [1:0]  b_sel;
  logic        b_in_valid;
  logic        b_in_ready;
  logic [7:0]  b_out_data;
  logic        b_out_valid;
  logic        b_out_ready;
  logic        b_sel_err;
  logic [15:0] b_beat_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  mux_pipe #(.WIDTH(8), .N(4), .CNTW(4)) dut_a (
    .clk       (clk),
    .rst       (rst),
    .data_in   (a_data_in),
    .sel       (a_sel),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .out_data  (a_out_data),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .sel_err   (a_sel_err),
    .beat_cnt  (a_beat_cnt)
  );

  mux_pipe #(.WIDTH(8), .N(3), .CNTW(16)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .data_in   (b_data_in),
    .sel       (b_sel),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .out_data  (b_out_data),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .sel_err   (b_sel_err),
    .beat_cnt  (b_beat_cnt)
  );

  // Free-running clock, 10 time units per period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the 4-source instance handshake inputs
  task automatic applyStimulus(input logic v, input logic [1:0] s, input logic r);
    a_in_valid  = v;
    a_sel       = s;
    a_out_ready = r;
  endtask

  // One counted comparison
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Directed sequence
  initial begin
    logic [7:0] src [4];
    src[0] = 8'h11; src[1] = 8'h22; src[2] = 8'h33; src[3] = 8'h44;

    rst         = 1'b1;
    a_data_in   = {8'h44, 8'h33, 8'h22, 8'h11};
    b_data_in   = {8'hC3, 8'hB2, 8'hA1};
    applyStimulus(1'b0, 2'd0, 1'b0);
    b_sel       = 2'd0;
    b_in_valid  = 1'b0;
    b_out_ready = 1'b1;
    tick();
    tick();

    // Reset state
    checkOutput("rst_in_ready", 32'(a_in_ready), 32'h0);
    checkOutput("rst_out_valid", 32'(a_out_valid), 32'h0);
    checkOutput("rst_out_data", 32'(a_out_data), 32'h0);
    checkOutput("rst_beat_cnt", 32'(a_beat_cnt), 32'h0);
    rst = 1'b0;
    #1;
    checkOutput("rel_in_ready", 32'(a_in_ready), 32'h1);

    // Streaming 0,3,1,2
    applyStimulus(1'b1, 2'd0, 1'b1);
    tick();
    checkOutput("str0_valid", 32'(a_out_valid), 32'h1);
    checkOutput("str0_data", 32'(a_out_data), 32'h11);
    a_sel = 2'd3;
    tick();
    checkOutput("str1_data", 32'(a_out_data), 32'h44);
    a_sel = 2'd1;
    tick();
    checkOutput("str2_data", 32'(a_out_data), 32'h22);
    checkOutput("str2_in_ready", 32'(a_in_ready), 32'h1);
    a_sel = 2'd2;
    tick();
    checkOutput("str3_data", 32'(a_out_data), 32'h33);
    checkOutput("str_cnt", 32'(a_beat_cnt), 32'h4);
    a_in_valid = 1'b0;
    tick();
    checkOutput("str_drain_valid", 32'(a_out_valid), 32'h0);
    checkOutput("str_hold_data", 32'(a_out_data), 32'h33);

    // Back-pressure with three beats
    applyStimulus(1'b1, 2'd0, 1'b0);
    tick();
    checkOutput("bp1_data", 32'(a_out_data), 32'h11);
    checkOutput("bp1_in_ready", 32'(a_in_ready), 32'h1);
    a_sel = 2'd1;
    tick();
    checkOutput("bp2_in_ready", 32'(a_in_ready), 32'h0);
    checkOutput("bp2_data", 32'(a_out_data), 32'h11);
    a_sel = 2'd2;
    tick();
    checkOutput("bp3_stall_data", 32'(a_out_data), 32'h11);
    checkOutput("bp3_stall_cnt", 32'(a_beat_cnt), 32'h6);
    a_out_ready = 1'b1;
    tick();
    checkOutput("bp_rel1_data", 32'(a_out_data), 32'h22);
    checkOutput("bp_rel1_cnt", 32'(a_beat_cnt), 32'h6);
    checkOutput("bp_rel1_in_ready", 32'(a_in_ready), 32'h1);
    tick();
    checkOutput("bp_rel2_data", 32'(a_out_data), 32'h33);
    checkOutput("bp_rel2_cnt", 32'(a_beat_cnt), 32'h7);
    a_in_valid = 1'b0;
    tick();
    checkOutput("bp_empty_valid", 32'(a_out_valid), 32'h0);

    // Ten beats of simultaneous accept and drain
    applyStimulus(1'b1, 2'd0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      a_sel = 2'(i % 4);
      tick();
      checkOutput($sformatf("ad%0d_valid", i), 32'(a_out_valid), 32'h1);
      checkOutput($sformatf("ad%0d_data", i), 32'(a_out_data), 32'(src[i % 4]));
      checkOutput($sformatf("ad%0d_in_ready", i), 32'(a_in_ready), 32'h1);
    end
    a_in_valid = 1'b0;
    tick();
    // 4 + 3 + 10 = 17 accepted beats on a 4-bit counter
    checkOutput("wrap_cnt", 32'(a_beat_cnt), 32'h1);
    checkOutput("a_sel_err", 32'(a_sel_err), 32'h0);

    // Out-of-range select on the 3-source instance
    b_in_valid = 1'b1;
    b_sel      = 2'd1;
    tick();
    checkOutput("oor_pre_data", 32'(b_out_data), 32'hB2);
    checkOutput("oor_pre_err", 32'(b_sel_err), 32'h0);
    b_sel = 2'd3;
    tick();
    checkOutput("oor_data", 32'(b_out_data), 32'h0);
    checkOutput("oor_valid", 32'(b_out_valid), 32'h1);
    checkOutput("oor_err", 32'(b_sel_err), 32'h1);
    b_sel = 2'd2;
    tick();
    checkOutput("oor_post1_data", 32'(b_out_data), 32'hC3);
    checkOutput("oor_post1_err", 32'(b_sel_err), 32'h1);
    b_sel = 2'd0;
    tick();
    checkOutput("oor_post2_data", 32'(b_out_data), 32'hA1);
    b_in_valid = 1'b0;
    tick();
    checkOutput("oor_sticky_err", 32'(b_sel_err), 32'h1);
    checkOutput("oor_cnt", 32'(b_beat_cnt), 32'h4);

    // Fill the buffer, then reset mid-stream
    applyStimulus(1'b1, 2'd1, 1'b0);
    tick();
    a_sel = 2'd2;
    tick();
    checkOutput("full_in_ready", 32'(a_in_ready), 32'h0);
    checkOutput("full_data", 32'(a_out_data), 32'h22);
    applyStimulus(1'b1, 2'd3, 1'b1);
    rst = 1'b1;
    #1;
    checkOutput("mrst_out_valid", 32'(a_out_valid), 32'h0);
    checkOutput("mrst_out_data", 32'(a_out_data), 32'h0);
    checkOutput("mrst_cnt", 32'(a_beat_cnt), 32'h0);
    checkOutput("mrst_in_ready", 32'(a_in_ready), 32'h0);
    checkOutput("mrst_b_sel_err", 32'(b_sel_err), 32'h0);
    tick();
    checkOutput("mrst_hold_valid", 32'(a_out_valid), 32'h0);
    checkOutput("mrst_hold_cnt", 32'(a_beat_cnt), 32'h0);
    a_in_valid = 1'b0;
    rst = 1'b0;
    tick();
    checkOutput("post_rst_in_ready", 32'(a_in_ready), 32'h1);
    checkOutput("post_rst_valid", 32'(a_out_valid), 32'h0);
    applyStimulus(1'b1, 2'd3, 1'b1);
    tick();
    checkOutput("post_rst_data", 32'(a_out_data), 32'h44);
    checkOutput("post_rst_cnt", 32'(a_beat_cnt), 32'h1);
    a_in_valid = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
